// File: rtl/req_pkg.sv
// Shared constants, FSM state encoding and a one-hot to index helper for the
// round-robin request scheduler.
package req_pkg;

    localparam int NREQ = 8;
    localparam int PW   = 3;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | (oh[i] ? PW'(i) : '0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or above ptr,
// wrapping from the top index back to 0.
module rr_pick #(
    parameter int NREQ = 8,
    parameter int PW   = 3
) (
    input  logic [NREQ-1:0] pending,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            found
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // PW-bit addition wraps the scan naturally for NREQ = 2**PW.
            idx = ptr + PW'(i);
            if (!found && pending[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_rr_sched.sv
// Edge-triggered round-robin request scheduler with a registered one-hot grant.
// Optional build macro REQ_RR_OVF_EN adds the sticky per-line overflow flags ovf_o.
module req_rr_sched
    import req_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int PW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [NREQ-1:0] pend_o,
`ifdef REQ_RR_OVF_EN
    output logic [NREQ-1:0] ovf_o,
`endif
    output state_t          state_o
);

    // Handshake: grant_o is transferred on any edge where valid_o and ready_i
    // are both 1; while ready_i is 0 the grant and valid_o hold unchanged.

    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] grant_q;
    logic            valid_q;
    logic [PW-1:0]   ptr;
    state_t          state;

    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] clr;
    logic            hs;
    logic [PW-1:0]   g_idx;
    logic [NREQ-1:0] pick_pend;
    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] winner;
    logic            found;

    assign rise  = req_i & ~req_q;
    assign hs    = valid_q & ready_i;
    assign clr   = hs ? grant_q : '0;
    assign g_idx = onehot_idx(grant_q);

    // In GRANT the picker looks ahead past the current grant so the next winner
    // can be loaded on the handshake edge; this cycle's rises are excluded.
    always_comb begin
        pick_pend = pending;
        pick_ptr  = ptr;
        if (state == GRANT) begin
            pick_pend = pending & ~grant_q;
            pick_ptr  = g_idx + PW'(1);
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .pending (pick_pend),
        .ptr     (pick_ptr),
        .winner  (winner),
        .found   (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
            state   <= IDLE;
        end else begin
            req_q   <= req_i;
            // A rise on the bit being cleared re-sets it: set wins.
            pending <= (pending & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= winner;
                        valid_q <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (hs) begin
                        ptr <= g_idx + PW'(1);
                        if (found) begin
                            grant_q <= winner;
                        end else begin
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_RR_OVF_EN
    logic [NREQ-1:0] ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (rise & pending & ~clr);
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign grant_o = grant_q;
    assign valid_o = valid_q;
    assign pend_o  = pending;
    assign state_o = state;

endmodule

// File: doc/req_rr_sched.md
REQ_RR_SCHED -- requirements
Module: req_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 8, giving the number of request lines; only 8 is supported, matching the downstream 8-to-3 encoder.
REQ-002 SHALL have parameter PW, default 3, giving the pointer width; PW = log2(NREQ).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_i, input, NREQ bits: level request lines, synchronous to clk.
REQ-006 SHALL have port grant_o, output, NREQ bits: registered one-hot grant that feeds the encoder's i0..i7.
REQ-007 SHALL have port valid_o, output, 1 bit: grant_o holds a valid one-hot value.
REQ-008 SHALL have port ready_i, input, 1 bit: the downstream stage accepts grant_o this cycle.
REQ-009 SHALL have port pend_o, output, NREQ bits: the current pending register, for observation.

Function
REQ-010 SHALL register req_i into req_q each cycle, and detect a rise on bit k when req_i[k]=1 and req_q[k]=0.
REQ-011 SHALL set pending[k] at the clock edge on which a rise on bit k is detected; pending bits are sticky.
REQ-012 SHALL implement a 2-state FSM with states IDLE and GRANT.
REQ-013 In IDLE with pending!=0, SHALL load grant_o with the round-robin winner, set valid_o=1, and move to GRANT; with pending==0 it SHALL stay in IDLE with valid_o=0.
REQ-014 Round-robin winner SHALL be the first set pending bit found scanning from index ptr upward, wrapping 7->0.
REQ-015 In GRANT, grant_o and valid_o SHALL hold stable while ready_i=0.
REQ-016 On a handshake (valid_o and ready_i both 1), SHALL clear pending[g], where g is the granted index, and set ptr = (g+1) mod 8.
REQ-017 On a handshake, if (pending & ~grant_o)!=0, SHALL load the next winner (scanning from the new ptr) in the same edge and stay in GRANT; otherwise SHALL go to IDLE with valid_o=0.
REQ-018 Rises detected in the handshake cycle SHALL set their pending bits but SHALL NOT take part in that cycle's arbitration.
REQ-019 If a rise on bit g coincides with the handshake clearing bit g, set SHALL win and pending[g] SHALL remain 1.
REQ-020 Latency from a rise on an idle block to valid_o=1 SHALL be 2 clock edges; throughput SHALL be one grant per cycle when ready_i is held at 1.
REQ-021 grant_o SHALL always be one-hot when valid_o=1 and all-zero when valid_o=0.

Reset
REQ-022 While rst=1, SHALL asynchronously force req_q=0, pending=0, ptr=0, state IDLE, grant_o=0, valid_o=0 and pend_o=0.
REQ-023 Reset asserted mid-GRANT SHALL drop the grant without a handshake.
REQ-024 Bits held high through reset deassertion SHALL register as rises on the first edge after deassertion.

Configuration
REQ-025 Macro REQ_RR_OVF_EN, when defined, SHALL add output ovf_o (NREQ bits), set sticky when a rise on bit k arrives while pending[k]=1 and not being cleared that cycle; ovf_o SHALL be cleared only by rst.
REQ-026 Without REQ_RR_OVF_EN, ovf_o and its logic SHALL be absent, and repeated rises on a pending bit SHALL be silently merged.

Structure
REQ-027 SHALL use shared package req_pkg, holding the NREQ and PW localparams and the FSM state type (IDLE, GRANT).
REQ-028 SHALL use sub-module rr_pick as a purely combinational block: inputs pending and ptr, outputs a one-hot winner and a found flag.

Verification
REQ-029 Scenario, single request: req_i=8'h04 rises, ready_i=1 -> two edges later grant_o=8'h04 and valid_o=1 for 1 cycle, then ptr=3 and pend_o=0.
REQ-030 Scenario, all requests at once: req_i=8'hFF rises, ptr=0, ready_i=1 -> grant_o sequence 01,02,04,08,10,20,40,80 on consecutive cycles, then valid_o=0.
REQ-031 Scenario, backpressure: ready_i=0 for 5 cycles with grant_o=8'h10 -> grant_o and valid_o stable; after ready_i=1, the next grant is the lowest pending bit at or above index 5.
REQ-032 Scenario, wrap-around: ptr=6 and pending=8'h41 -> grant_o=8'h40, then 8'h01.
REQ-033 Scenario, collision: a rise on bit 2 in its own handshake cycle -> pend_o[2] stays 1, and with REQ_RR_OVF_EN defined, ovf_o[2] stays 0.
REQ-034 Scenario, reset mid-operation: rst pulsed while valid_o=1 -> valid_o=0, grant_o=0 and pend_o=0 immediately, with no clock edge required.
